// File: rtl/playback_addr_seq_if.sv
`default_nettype none
// =============================================================================
// Module   : playback_addr_seq_if
// Brief    : Control/status bundle between the button/track front-end and the
//            playback address sequencer. PLAYBACK_LOOP_EN adds loop_mode.
// Revision : 1.0 - initial release
// =============================================================================
interface playback_addr_seq_if #(
    parameter int ADDR_W = 22,
    parameter int TIME_W = 9
);
    logic                     load;
    logic [ADDR_W-1:0]        track_start;
    logic [ADDR_W-1:0]        track_end;
    logic                     count;
    logic                     passa_10s;
    logic                     volta_10s;
    logic                     passa_30s;
    logic                     volta_30s;
`ifdef PLAYBACK_LOOP_EN
    logic                     loop_mode;
`endif
    logic [ADDR_W-1:0]        endereco;
    logic signed [TIME_W-1:0] time_adder;
    logic                     time_valid;
    logic                     prox_musica;
    logic                     playing;

    modport master (
        output load, track_start, track_end, count,
        output passa_10s, volta_10s, passa_30s, volta_30s,
`ifdef PLAYBACK_LOOP_EN
        output loop_mode,
`endif
        input  endereco, time_adder, time_valid, prox_musica, playing
    );

    modport slave (
        input  load, track_start, track_end, count,
        input  passa_10s, volta_10s, passa_30s, volta_30s,
`ifdef PLAYBACK_LOOP_EN
        input  loop_mode,
`endif
        output endereco, time_adder, time_valid, prox_musica, playing
    );
endinterface
`default_nettype wire

// File: rtl/playback_addr_seq.sv
`default_nettype none
// =============================================================================
// Module   : playback_addr_seq
// Brief    : Sample-address sequencer for the current track with pacing,
//            short/long seeks and end-of-track pulse. Optional PLAYBACK_LOOP_EN.
// Revision : 1.0 - initial release
// =============================================================================
module playback_addr_seq #(
    parameter int ADDR_W          = 22,
    parameter int SAMPLE_DIV      = 1,
    parameter int SAMPLES_PER_SEC = 8000,
    parameter int SHORT_SEEK_S    = 10,
    parameter int LONG_SEEK_S     = 30,
    parameter int TIME_W          = 9
) (
    input  logic               clk,
    input  logic               reset,
    playback_addr_seq_if.slave bus
);

    localparam int PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [PRE_W-1:0]         c_pre_last    = PRE_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W:0]          c_step_short  = (ADDR_W+1)'(SHORT_SEEK_S * SAMPLES_PER_SEC);
    localparam logic [ADDR_W:0]          c_step_long   = (ADDR_W+1)'(LONG_SEEK_S * SAMPLES_PER_SEC);
    localparam logic signed [TIME_W-1:0] c_t_short_fwd = TIME_W'(SHORT_SEEK_S);
    localparam logic signed [TIME_W-1:0] c_t_short_bwd = TIME_W'(-SHORT_SEEK_S);
    localparam logic signed [TIME_W-1:0] c_t_long_fwd  = TIME_W'(LONG_SEEK_S);
    localparam logic signed [TIME_W-1:0] c_t_long_bwd  = TIME_W'(-LONG_SEEK_S);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        endereco_q;
    logic [ADDR_W-1:0]        start_q;
    logic [ADDR_W-1:0]        end_q;
    logic [PRE_W-1:0]         presc_q;
    logic [3:0]               btn_q;
    logic signed [TIME_W-1:0] time_q;
    logic                     time_valid_q;
    logic                     prox_q;

    logic [3:0]               w_btn;
    logic [3:0]               w_req;
    logic                     w_loop;
    logic                     w_seek_vld;
    logic                     w_seek_fwd;
    logic [ADDR_W:0]          w_seek_step;
    logic signed [TIME_W-1:0] w_seek_time;
    logic [ADDR_W:0]          w_fwd_sum;
    logic [ADDR_W:0]          w_bwd_diff;
    logic                     w_fwd_ok;
    logic                     w_bwd_ok;
    logic                     w_seek_ok;
    logic [ADDR_W-1:0]        w_addr_inc;
    logic                     w_at_end;
    logic                     w_hits_end;

`ifdef PLAYBACK_LOOP_EN
    assign w_loop = bus.loop_mode;
`else
    assign w_loop = 1'b0;
`endif

    // Bit order doubles as seek priority: passa_30s > passa_10s > volta_30s > volta_10s
    assign w_btn = {bus.passa_30s, bus.passa_10s, bus.volta_30s, bus.volta_10s};
    assign w_req = w_btn & ~btn_q;

    always_comb begin
        w_seek_vld  = 1'b0;
        w_seek_fwd  = 1'b0;
        w_seek_step = '0;
        w_seek_time = '0;
        if (w_req[3]) begin
            w_seek_vld  = 1'b1;
            w_seek_fwd  = 1'b1;
            w_seek_step = c_step_long;
            w_seek_time = c_t_long_fwd;
        end else if (w_req[2]) begin
            w_seek_vld  = 1'b1;
            w_seek_fwd  = 1'b1;
            w_seek_step = c_step_short;
            w_seek_time = c_t_short_fwd;
        end else if (w_req[1]) begin
            w_seek_vld  = 1'b1;
            w_seek_step = c_step_long;
            w_seek_time = c_t_long_bwd;
        end else if (w_req[0]) begin
            w_seek_vld  = 1'b1;
            w_seek_step = c_step_short;
            w_seek_time = c_t_short_bwd;
        end
    end

    // One extra bit so a seek past either bound is rejected instead of wrapping
    assign w_fwd_sum  = {1'b0, endereco_q} + w_seek_step;
    assign w_bwd_diff = {1'b0, endereco_q} - w_seek_step;
    assign w_fwd_ok   = (w_fwd_sum < {1'b0, end_q});
    assign w_bwd_ok   = !w_bwd_diff[ADDR_W] && (w_bwd_diff[ADDR_W-1:0] >= start_q);
    assign w_seek_ok  = w_seek_vld && (w_seek_fwd ? w_fwd_ok : w_bwd_ok);
    assign w_addr_inc = endereco_q + ADDR_W'(1);
    assign w_at_end   = (endereco_q == end_q);
    assign w_hits_end = (w_addr_inc == end_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            endereco_q   <= '0;
            start_q      <= '0;
            end_q        <= '0;
            presc_q      <= '0;
            btn_q        <= '0;
            time_q       <= '0;
            time_valid_q <= 1'b0;
            prox_q       <= 1'b0;
        end else begin
            btn_q        <= w_btn;
            time_valid_q <= 1'b0;
            prox_q       <= 1'b0;
            if (bus.load) begin
                state_q    <= ST_RUN;
                endereco_q <= bus.track_start;
                start_q    <= bus.track_start;
                end_q      <= bus.track_end;
                presc_q    <= '0;
                time_q     <= '0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (w_seek_ok) begin
                            time_q       <= w_seek_time;
                            time_valid_q <= 1'b1;
                            if (w_seek_fwd) begin
                                endereco_q <= w_fwd_sum[ADDR_W-1:0];
                                presc_q    <= '0;
                            end else begin
                                endereco_q <= w_bwd_diff[ADDR_W-1:0];
                            end
                        end else if (bus.count) begin
                            if (presc_q != c_pre_last) begin
                                presc_q <= presc_q + PRE_W'(1);
                            end else begin
                                presc_q <= '0;
                                // Sitting on track_end is only possible while looping
                                if (w_at_end && w_loop) begin
                                    endereco_q <= start_q;
                                end else if (w_at_end) begin
                                    state_q <= ST_DONE;
                                    prox_q  <= 1'b1;
                                end else begin
                                    endereco_q <= w_addr_inc;
                                    if (w_hits_end && !w_loop) begin
                                        state_q <= ST_DONE;
                                        prox_q  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.endereco    = endereco_q;
    assign bus.time_adder  = time_q;
    assign bus.time_valid  = time_valid_q;
    assign bus.prox_musica = prox_q;
    assign bus.playing     = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_playback_addr_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_playback_addr_seq
// Brief    : Directed self-checking bench for playback_addr_seq
//            (SAMPLE_DIV=2, 4 samples/s, seek steps 40/120).
// Revision : 1.0 - initial release
// =============================================================================
module tb_playback_addr_seq;

    localparam int ADDR_W = 22;
    localparam int TIME_W = 9;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k_hit;
    int   prox_seen;

    playback_addr_seq_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W)) bus ();

    playback_addr_seq #(
        .ADDR_W          (ADDR_W),
        .SAMPLE_DIV      (2),
        .SAMPLES_PER_SEC (4),
        .SHORT_SEEK_S    (10),
        .LONG_SEEK_S     (30),
        .TIME_W          (TIME_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {passa_30s, passa_10s, volta_30s, volta_10s}
    task automatic set_btn(input logic [3:0] b);
        {bus.passa_30s, bus.passa_10s, bus.volta_30s, bus.volta_10s} = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load        = 1'b0;
        bus.track_start = '0;
        bus.track_end   = '0;
        bus.count       = 1'b0;
        set_btn(4'h0);
`ifdef PLAYBACK_LOOP_EN
        bus.loop_mode   = 1'b0;
`endif
        #12;
        check("rst_addr",    bus.endereco, 0);
        check("rst_playing", bus.playing, 0);
        check("rst_time",    $signed(bus.time_adder), 0);
        check("rst_prox",    bus.prox_musica, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // EMPTY: count and seeks must be ignored
        for (int i = 0; i < 6; i++) begin
            bus.count = i[0];
            set_btn(i[0] ? 4'hF : 4'h0);
            tick(1);
            check("empty_addr", bus.endereco, 0);
            check("empty_tv",   bus.time_valid, 0);
            check("empty_play", bus.playing, 0);
        end

        // Load 100..400 and play 20 clocks
        set_btn(4'h0);
        bus.count       = 1'b0;
        bus.track_start = 22'd100;
        bus.track_end   = 22'd400;
        bus.load        = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        bus.count = 1'b1;
        check("load_addr", bus.endereco, 100);
        check("load_play", bus.playing, 1);
        tick(20);
        check("play20_addr", bus.endereco, 110);
        check("play20_play", bus.playing, 1);

        // passa_10s held 5 cycles -> single +40 step
        set_btn(4'b0100);
        tick(1);
        check("p10_addr", bus.endereco, 150);
        check("p10_time", $signed(bus.time_adder), 10);
        check("p10_tv",   bus.time_valid, 1);
        tick(1);
        check("p10_tv_drop", bus.time_valid, 0);
        check("p10_hold",    bus.endereco, 150);
        tick(3);
        check("p10_once", bus.endereco, 152);

        // volta_30s rejected (152-120 < 100), playback continues
        set_btn(4'b0010);
        tick(1);
        check("v30_rej_addr", bus.endereco, 152);
        check("v30_rej_tv",   bus.time_valid, 0);
        set_btn(4'h0);
        tick(1);
        check("v30_adv", bus.endereco, 153);

        // volta_10s accepted
        set_btn(4'b0001);
        tick(1);
        check("v10_addr", bus.endereco, 113);
        check("v10_time", $signed(bus.time_adder), -10);
        check("v10_tv",   bus.time_valid, 1);

        // Pause freezes address, time_adder holds
        set_btn(4'h0);
        bus.count = 1'b0;
        tick(3);
        check("pause_addr", bus.endereco, 113);
        check("pause_time", $signed(bus.time_adder), -10);

        // passa_30s + volta_10s together -> only +120 (accepted while paused)
        set_btn(4'b1001);
        tick(1);
        check("dual_addr", bus.endereco, 233);
        check("dual_time", $signed(bus.time_adder), 30);
        check("dual_tv",   bus.time_valid, 1);
        set_btn(4'h0);
        bus.count = 1'b1;

        // Run to end: 167 advances at 2 clk each
        k_hit = -1;
        for (int k = 1; k <= 400; k++) begin
            tick(1);
            if (bus.prox_musica && k_hit < 0) k_hit = k;
            if (k_hit >= 0) break;
        end
        check("end_cycle", k_hit, 334);
        check("end_addr",  bus.endereco, 400);
        check("end_play",  bus.playing, 0);
        set_btn(4'b0001);
        tick(1);
        check("done_prox_1cyc", bus.prox_musica, 0);
        check("done_addr",      bus.endereco, 400);
        check("done_seek_ign",  bus.time_valid, 0);
        set_btn(4'h0);

        // Reload 100..140 with a simultaneous seek edge (discarded)
        bus.count     = 1'b0;
        bus.track_end = 22'd140;
        bus.load      = 1'b1;
        set_btn(4'b0100);
        tick(1);
        bus.load = 1'b0;
        check("reload_addr", bus.endereco, 100);
        check("reload_tv",   bus.time_valid, 0);
        check("reload_time", $signed(bus.time_adder), 0);
        check("reload_play", bus.playing, 1);
        set_btn(4'h0);
        tick(1);
        set_btn(4'b0100);
        tick(1);
        check("fwd_eq_end_addr", bus.endereco, 100);
        check("fwd_eq_end_tv",   bus.time_valid, 0);
        set_btn(4'h0);
        tick(1);
        set_btn(4'b0001);
        tick(1);
        check("bwd_below_start", bus.endereco, 100);
        check("bwd_below_tv",    bus.time_valid, 0);
        set_btn(4'h0);

        // 100..141: +40 lands on 140, one advance reaches end
        bus.track_end = 22'd141;
        bus.load      = 1'b1;
        tick(1);
        bus.load = 1'b0;
        set_btn(4'b0100);
        tick(1);
        check("fwd_last_addr", bus.endereco, 140);
        check("fwd_last_tv",   bus.time_valid, 1);
        set_btn(4'h0);
        bus.count = 1'b1;
        tick(1);
        check("pre_end_prox", bus.prox_musica, 0);
        tick(1);
        check("end2_addr", bus.endereco, 141);
        check("end2_prox", bus.prox_musica, 1);
        check("end2_play", bus.playing, 0);

`ifdef PLAYBACK_LOOP_EN
        bus.count       = 1'b0;
        bus.loop_mode   = 1'b1;
        bus.track_start = 22'd100;
        bus.track_end   = 22'd103;
        bus.load        = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        bus.count = 1'b1;
        prox_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (bus.prox_musica) prox_seen = 1;
        end
        check("loop_at_end", bus.endereco, 103);
        for (int k = 0; k < 2; k++) begin
            tick(1);
            if (bus.prox_musica) prox_seen = 1;
        end
        check("loop_wrap", bus.endereco, 100);
        check("loop_play", bus.playing, 1);
        check("loop_noprox", prox_seen, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/playback_addr_seq.md
Name: playback_addr_seq

Overview:
- Parametrised successor of the current-address state machine for the music player.
- Generates the sample-memory read address of the current track between programmable start/end bounds.
- Supports a configurable sample pacing divider and two configurable seek distances (short/long, forward/back).
- Reports each accepted seek as a signed seconds delta and pulses `prox_musica` at end of track; sits between the button debouncers and the audio memory reader.

Parameters:
- ADDR_W, 22, width of sample address and track bounds
- SAMPLE_DIV, 1, clk cycles per sample advance (>=1)
- SAMPLES_PER_SEC, 8000, samples per second of audio
- SHORT_SEEK_S, 10, short seek distance in seconds
- LONG_SEEK_S, 30, long seek distance in seconds
- TIME_W, 9, width of signed time_adder (must hold +/-LONG_SEEK_S)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe: latch track bounds, restart track
- track_start  in  ADDR_W  first sample address of track
- track_end  in  ADDR_W  last sample address of track (must be > track_start)
- count  in  1  1 = play (advance), 0 = pause
- passa_10s  in  1  short forward seek request (level, edge-detected)
- volta_10s  in  1  short backward seek request
- passa_30s  in  1  long forward seek request
- volta_30s  in  1  long backward seek request
- endereco  out  ADDR_W  current sample address
- time_adder  out  TIME_W signed  seconds delta of last accepted seek
- time_valid  out  1  one-cycle pulse when time_adder updated
- prox_musica  out  1  one-cycle pulse at end of track
- playing  out  1  1 in RUN state

Behaviour:
- Reset (async, reset=0): state EMPTY, endereco=0, time_adder=0, time_valid=0, prox_musica=0, prescaler=0, latched bounds=0, button history=0.
- Steps: S_SHORT = SHORT_SEEK_S*SAMPLES_PER_SEC; S_LONG = LONG_SEEK_S*SAMPLES_PER_SEC.
  - Compare in ADDR_W+1 bits; no wrap-around anywhere.
- Button edges: request = btn & ~btn_q; btn_q is registered every cycle in all states.
  - Level held high produces exactly one request.
- States:
  - EMPTY: ignore count and seeks; load -> RUN.
  - RUN: play, seek, end detection.
  - DONE: endereco held at track_end; seeks ignored; load -> RUN.
- Load (any state, highest priority):
  - Next cycle: endereco=track_start, prescaler=0, bounds latched.
  - A simultaneous seek edge is consumed and discarded.
- Playback in RUN, count=1:
  - Prescaler counts 0..SAMPLE_DIV-1.
  - On the cycle it equals SAMPLE_DIV-1, endereco+=1 and prescaler=0.
- Pause: count=0 freezes prescaler and endereco; seeks still accepted.
- Seek priority (one per cycle, others discarded): passa_30s > passa_10s > volta_30s > volta_10s.
- Forward seek by S:
  - Accepted iff endereco+S < track_end: endereco+=S, prescaler=0, time_adder=+seconds, time_valid=1.
  - Otherwise ignored: no change, no time_valid.
- Backward seek by S:
  - Accepted iff endereco-S >= track_start: endereco-=S, time_adder=-seconds, time_valid=1.
  - Otherwise ignored.
- Seek latency: endereco and time_adder change on the first clk edge after the edge-detect cycle.
  - Seek overrides that cycle's sample advance.
- End of track: advance that makes endereco==track_end -> next state DONE.
  - prox_musica=1 for exactly that one cycle.
- time_adder holds its value until the next accepted seek, load (-> 0) or reset.
- `playing` = (state==RUN).

Optional Feature:
- Macro: PLAYBACK_LOOP_EN.
- Defined:
  - Adds input `loop_mode` (1 bit).
  - In RUN with loop_mode=1, reaching track_end reloads endereco=track_start on the next advance; state stays RUN; prox_musica not pulsed.
  - loop_mode=0 behaves as below.
- Undefined: no loop_mode port; end of track always enters DONE with a prox_musica pulse.

Test Plan (SAMPLE_DIV=2, SAMPLES_PER_SEC=4, SHORT=10, LONG=30 -> steps 40/120):
- Reset low then high, no load -> endereco=0, playing=0; toggling count/seeks leaves all outputs 0.
- load start=100 end=400, count=1 for 20 clk -> endereco=110, playing=1.
- At endereco=110, pulse passa_10s high for 5 cycles -> endereco=150 (one step only), time_adder=+10, time_valid high for 1 cycle.
- At endereco=150, volta_30s -> ignored (150-120<100), endereco keeps advancing.
  - Then volta_10s -> endereco-=40, time_adder=-10.
- passa_30s and volta_10s rising in the same cycle -> only +120 applied, time_adder=+30.
- Run to 400 -> prox_musica one cycle, endereco holds 400, playing=0; load restarts at 100.
  - With PLAYBACK_LOOP_EN and loop_mode=1 -> endereco goes 400->100, no prox_musica.
